i2s_rx: RTL and testbench

- Upstream stage of the effects core.
- Deserialises a stereo I2S stream (sck, ws, sdata), which arrives asynchronous to the system clock, into one 32-bit parallel frame per WS period.
- Presents each frame on a valid/ready interface; the effects chain consumes it as its input sample.
- Oversamples sck/ws/sdata in the system clock domain; no second clock.

---
 rtl/i2s_rx.sv | 126 ++++++++++++
 tb/tb_i2s_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sdata in the clk domain and emits one
// {left, right} frame per WS period on a valid/ready interface.
module i2s_rx #(
    parameter int WORD_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sck,
    input  logic                   ws,
    input  logic                   serial_data_in,
    input  logic                   sample_ready,
    output logic [2*WORD_BITS-1:0] sample_out,
    output logic                   sample_valid,
    output logic                   overrun,
    output logic                   synced
);

    localparam int CW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(WORD_BITS);
    localparam logic [WORD_BITS-1:0] TOP = {1'b1, {(WORD_BITS-1){1'b0}}};

    typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_q, ws_q, sd_q;
    logic sck_s, ws_s, sd_s, sck_d, ws_prev;
    logic sck_event, ws_rise, ws_fall;

    logic [CW-1:0] bit_cnt;
    logic [WORD_BITS-1:0] left_sr, right_sr, right_cap, bit_mask;

    logic cap_en, cap_left, cap_right, clr_left, clr_right, commit;
    logic transfer, load;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= '0;
            ws_q  <= '0;
            sd_q  <= '0;
            sck_d <= 1'b0;
        end else begin
            sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
            ws_q  <= {ws_q[SYNC_STAGES-2:0], ws};
            sd_q  <= {sd_q[SYNC_STAGES-2:0], serial_data_in};
            sck_d <= sck_s;
        end
    end

    assign sck_s = sck_q[SYNC_STAGES-1];
    assign ws_s  = ws_q[SYNC_STAGES-1];
    assign sd_s  = sd_q[SYNC_STAGES-1];

    assign sck_event = sck_s & ~sck_d;
    assign ws_rise   = sck_event & ws_s & ~ws_prev;
    assign ws_fall   = sck_event & ~ws_s & ws_prev;

    always_ff @(posedge clk) begin
        if (rst) state <= ALIGN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ALIGN:   if (ws_fall) state_nx = LEFT;
            LEFT:    if (ws_rise) state_nx = RIGHT;
            RIGHT:   if (ws_fall) state_nx = LEFT;
            default: state_nx = ALIGN;
        endcase
    end

    always_comb begin
        cap_en    = sck_event && (state != ALIGN) && (bit_cnt < FULL);
        cap_left  = cap_en && (state == LEFT);
        cap_right = cap_en && (state == RIGHT);
        clr_left  = (state_nx == LEFT) && (state != LEFT);
        clr_right = (state_nx == RIGHT) && (state != RIGHT);
        commit    = (state == RIGHT) && ws_fall;
    end

    // Bits land MSB-first at their final position, so short words come
    // out left-justified with zero LSBs for free.
    assign bit_mask  = TOP >> bit_cnt;
    assign right_cap = (cap_right && sd_s) ? (right_sr | bit_mask) : right_sr;

    assign transfer = sample_valid && sample_ready;
    assign load     = commit && (!sample_valid || sample_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_prev      <= 1'b0;
            bit_cnt      <= '0;
            left_sr      <= '0;
            right_sr     <= '0;
            synced       <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (sck_event) ws_prev <= ws_s;

            if (state_nx != state) bit_cnt <= '0;
            else if (cap_en)       bit_cnt <= bit_cnt + CW'(1);

            if (clr_left)                left_sr <= '0;
            else if (cap_left && sd_s)   left_sr <= left_sr | bit_mask;

            if (clr_right) right_sr <= '0;
            else           right_sr <= right_cap;

            synced <= (state_nx != ALIGN);

            if (load) begin
                sample_out   <= {left_sr, right_cap};
                sample_valid <= 1'b1;
            end else if (transfer) begin
                sample_valid <= 1'b0;
            end

            if (commit && !load) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed + randomized bench for i2s_rx with a word-level reference model.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b0;
    logic        ws = 1'b0;
    logic        sdata = 1'b0;
    logic        sample_ready = 1'b0;
    logic [31:0] sample_out;
    logic        sample_valid;
    logic        overrun;
    logic        synced;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    i2s_rx #(.WORD_BITS(16), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .sck            (sck),
        .ws             (ws),
        .serial_data_in (sdata),
        .sample_ready   (sample_ready),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .overrun        (overrun),
        .synced         (synced)
    );

    always #5 clk = ~clk;

    // Transfers are recorded mid-cycle; inputs only move just after posedge.
    always @(negedge clk)
        if (!rst && sample_valid && sample_ready)
            got_q.push_back(sample_out);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sck period = 8 clk; ws/data change with the falling edge.
    task automatic slot(input logic w, input logic d);
        sck = 1'b0;
        ws = w;
        sdata = d;
        tick(4);
        sck = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                              input int n);
        for (int i = 0; i < n; i++) slot(i == n - 1, lw[n-1-i]);
        for (int j = 0; j < n; j++) slot(j != n - 1, rw[n-1-j]);
    endtask

    task automatic preamble(input int nhigh);
        for (int i = 0; i < nhigh; i++) slot(1'b1, 1'($urandom));
        slot(1'b0, 1'($urandom));
    endtask

    function automatic logic [15:0] just(input logic [31:0] w, input int n);
        if (n >= 16) return 16'(w >> (n - 16));
        return 16'(w << (16 - n));
    endfunction

    function automatic logic [31:0] model(input logic [31:0] lw,
                                          input logic [31:0] rw, input int n);
        return {just(lw, n), just(rw, n)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sck = 1'($urandom);
            ws = 1'($urandom);
            sdata = 1'($urandom);
            sample_ready = 1'($urandom);
            tick(1);
        end
        chk("rst_out", sample_out, 32'h0);
        chk("rst_valid", {31'b0, sample_valid}, 32'h0);
        chk("rst_overrun", {31'b0, overrun}, 32'h0);
        chk("rst_synced", {31'b0, synced}, 32'h0);
        rst = 1'b0;
        sck = 1'b0;
        ws = 1'b0;
        sdata = 1'b0;
        sample_ready = 1'b0;
        tick(2);
    endtask

    task automatic cmp_queues(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    endtask

    initial begin
        logic [31:0] lw, rw, f1, f2, f3;
        int n;

        tick(1);
        do_reset();

        // No frame before a ws 1->0 transition
        preamble(0);
        for (int i = 0; i < 3; i++) slot(1'b1, 1'($urandom));
        chk("pre_valid", {31'b0, sample_valid}, 32'h0);
        chk("pre_synced", {31'b0, synced}, 32'h0);
        slot(1'b0, 1'($urandom));
        chk("align_synced", {31'b0, synced}, 32'h1);
        chk("align_valid", {31'b0, sample_valid}, 32'h0);

        // Basic frame held until accepted
        got_q.delete();
        send_frame(32'hA55A, 32'h1234, 16);
        tick(2);
        chk("basic_valid", {31'b0, sample_valid}, 32'h1);
        chk("basic_out", sample_out, 32'hA55A1234);
        tick(5);
        chk("basic_hold", sample_out, 32'hA55A1234);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        chk("basic_drop", {31'b0, sample_valid}, 32'h0);
        exp_q = '{32'hA55A1234};
        cmp_queues("basic_xfer");

        // Back-to-back with ready tied high, directed then random
        got_q.delete();
        exp_q.delete();
        sample_ready = 1'b1;
        send_frame(32'h0001, 32'hFFFF, 16);
        exp_q.push_back(32'h0001_FFFF);
        send_frame(32'h8000, 32'h7FFF, 16);
        exp_q.push_back(32'h8000_7FFF);
        send_frame(32'hDEAD, 32'hBEEF, 16);
        exp_q.push_back(32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            lw = $urandom;
            rw = $urandom;
            send_frame(lw, rw, 16);
            exp_q.push_back(model(lw, rw, 16));
        end
        tick(3);
        cmp_queues("b2b");
        chk("b2b_overrun", {31'b0, overrun}, 32'h0);

        // Overrun: second commit while the first is still unread
        got_q.delete();
        sample_ready = 1'b0;
        lw = $urandom;
        rw = $urandom;
        f1 = model(lw, rw, 16);
        send_frame(lw, rw, 16);
        chk("ovr_first_no_flag", {31'b0, overrun}, 32'h0);
        lw = $urandom;
        rw = $urandom;
        f2 = model(lw, rw, 16);
        send_frame(lw, rw, 16);
        tick(2);
        chk("ovr_valid", {31'b0, sample_valid}, 32'h1);
        chk("ovr_kept", sample_out, f1);
        chk("ovr_flag", {31'b0, overrun}, 32'h1);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        tick(1);
        chk("ovr_drained", {31'b0, sample_valid}, 32'h0);
        sample_ready = 1'b1;
        lw = $urandom;
        rw = $urandom;
        f3 = model(lw, rw, 16);
        send_frame(lw, rw, 16);
        tick(3);
        exp_q = '{f1, f3};
        cmp_queues("ovr_xfer");
        chk("ovr_sticky", {31'b0, overrun}, 32'h1);
        if (f2 == f1) $display("note: f2 equals f1");

        // Word lengths: short, long, random
        do_reset();
        preamble(2);
        got_q.delete();
        exp_q.delete();
        sample_ready = 1'b1;
        send_frame(32'hABC, 32'h123, 12);
        exp_q.push_back(32'hABC0_1230);
        lw = {12'h0, 16'h1357, 4'($urandom)};
        rw = {12'h0, 16'h2468, 4'($urandom)};
        send_frame(lw, rw, 20);
        exp_q.push_back(32'h1357_2468);
        for (int k = 0; k < 2; k++) begin
            n = $urandom_range(24, 8);
            lw = $urandom;
            rw = $urandom;
            send_frame(lw, rw, n);
            exp_q.push_back(model(lw, rw, n));
        end
        tick(3);
        cmp_queues("wlen");
        chk("wlen_overrun", {31'b0, overrun}, 32'h0);

        // Reset in the middle of a left word
        got_q.delete();
        exp_q.delete();
        lw = $urandom;
        for (int i = 0; i < 7; i++) slot(1'b0, lw[15-i]);
        rst = 1'b1;
        tick(1);
        chk("mid_out", sample_out, 32'h0);
        chk("mid_valid", {31'b0, sample_valid}, 32'h0);
        chk("mid_synced", {31'b0, synced}, 32'h0);
        rst = 1'b0;
        tick(2);
        preamble(2);
        lw = $urandom;
        rw = $urandom;
        send_frame(lw, rw, 16);
        exp_q.push_back(model(lw, rw, 16));
        tick(3);
        cmp_queues("mid_after");
        chk("mid_overrun", {31'b0, overrun}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
